eros_domain_pwr_seq: RTL and testbench
======================================

Name: eros_domain_pwr_seq

Overview:
- Per-domain power sequencer for the EROS subsystem, replacing the fixed single clock gate plus raw pwrgate/retentive pass-through of the current top wrapper.
- Controls N_DOMAINS independent power domains (core harts, memory banks). Each domain has its own FSM that orders clock gating, isolation, retention and power-gate handshake on sleep and wake.
- Sits between the power manager and the ASIC macros and clock gates.

Parameters:
- N_DOMAINS, 3, number of independently sequenced domains.
- CG_DELAY, 2, cycles between clock-enable change and the next sequencing step (range 1..15).
- ACK_TIMEOUT, 255, cycles waiting for a macro ack before flagging an error (range 1..65535).

Ports:
- clk_i  input  1  free-running clock (ungated).
- rst_i  input  1  asynchronous active-high reset.
- sleep_req_i  input  N_DOMAINS  level request to power down domain d.
- wake_req_i  input  N_DOMAINS  level request to power up domain d.
- retain_i  input  N_DOMAINS  sampled at sleep start: 1 = keep retention during off.
- pwrgate_ack_ni  input  N_DOMAINS  macro ack, active-low; 0 = switch off confirmed.
- err_clear_i  input  1  one-cycle pulse; clears all error flags.
- clk_en_o  output  N_DOMAINS  clock-gate enable per domain.
- iso_o  output  N_DOMAINS  isolation enable (1 = isolated).
- set_retentive_no  output  N_DOMAINS  retention control, active-low.
- pwrgate_no  output  N_DOMAINS  power switch control, active-low (0 = off).
- domain_on_o  output  N_DOMAINS  1 only in state ON.
- busy_o  output  N_DOMAINS  1 in any transitional state.
- err_o  output  N_DOMAINS  sticky ack-timeout flag.
- irq_o  output  1  OR of err_o.

Behaviour:
- Reset values, for all domains and asserted asynchronously, including mid-sequence: state ON, clk_en_o=1, iso_o=0, set_retentive_no=1, pwrgate_no=1, domain_on_o=1, busy_o=0, err_o=0, irq_o=0, counters 0.
- All outputs are registered. Each domain FSM is independent, one state per cycle unless stated.
- Sleep path:
  - ON: if sleep_req_i && !wake_req_i, latch retain_i, go to CLK_OFF. Wake has priority on a tie, so the domain stays ON.
  - CLK_OFF: clk_en_o=0; hold CG_DELAY cycles, then go to ISO.
  - ISO: iso_o=1; 1 cycle, then go to RET.
  - RET: set_retentive_no = !retain_latched; 1 cycle, then go to PG.
  - PG: pwrgate_no=0; wait for pwrgate_ack_ni==0, then go to OFF.
- OFF: outputs held (clk_en=0, iso=1, pwrgate_no=0). If wake_req_i, go to PU. sleep_req_i is ignored.
- Wake path:
  - PU: pwrgate_no=1; wait for pwrgate_ack_ni==1, then go to UNRET.
  - UNRET: set_retentive_no=1; 1 cycle, then go to DEISO.
  - DEISO: iso_o=0; 1 cycle, then go to CLK_ON.
  - CLK_ON: hold CG_DELAY cycles, then set clk_en_o=1 and go to ON.
- Requests arriving in transitional states are ignored. A sequence always completes. Requests are level-sampled again only in ON or OFF.
- Sleep latency with immediate ack: domain_on_o falls the cycle after the request is sampled. OFF is reached CG_DELAY+3 cycles after leaving ON, plus ack wait.
- Timeout:
  - A per-domain counter runs in PG and PU and clears on state entry.
  - When it reaches ACK_TIMEOUT, err_o[d] is set. The FSM keeps waiting and the counter saturates.
  - err_clear_i clears err_o. Set has priority over clear in the same cycle.
- Counter width is $clog2(max(CG_DELAY,ACK_TIMEOUT)+1). There is no wrap-around.
- busy_o[d] = !(state ON || state OFF).

Test Plan:
- Reset then idle 10 cycles -> all domains: clk_en_o=1, iso_o=0, set_retentive_no=1, pwrgate_no=1, domain_on_o=1, err_o=0.
- Domain 0 with sleep_req=1, retain=1, ack returned 2 cycles after pwrgate_no falls, CG_DELAY=2 -> in order: clk_en_o[0]=0, 2 cycles later iso_o[0]=1, then set_retentive_no[0]=0, then pwrgate_no[0]=0; OFF after ack; domains 1 and 2 unchanged.
- Domain 1 OFF with retain=0, then wake_req=1 -> set_retentive_no stays 1 throughout. Order on wake: pwrgate_no=1, ack high, iso_o=0, clk_en_o=1 after 2 cycles, domain_on_o=1.
- Sleep of domain 2 with ack held high, ACK_TIMEOUT=255 -> err_o[2]=1 and irq_o=1 at cycle 255 in PG. Ack then arrives -> domain reaches OFF. err_clear_i pulse -> err_o=0.
- sleep_req and wake_req both high in ON -> domain stays ON. wake_req raised mid-sleep in ISO -> sleep completes to OFF, then wake starts.
- rst_i asserted while in PG -> all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/eros_domain_pwr_seq.sv
// eros_domain_pwr_seq
// Per-domain power sequencer. On sleep each domain gates its clock, isolates,
// optionally enters retention and then opens its power switch. Wake runs the
// same steps in reverse order. Waits on the power-switch handshake are timed,
// and a sticky error flag is raised if the macro is slow to acknowledge.
module eros_domain_pwr_seq #(
    parameter int N_DOMAINS   = 3,
    parameter int CG_DELAY    = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_DOMAINS-1:0] sleep_req_i,
    input  logic [N_DOMAINS-1:0] wake_req_i,
    input  logic [N_DOMAINS-1:0] retain_i,
    input  logic [N_DOMAINS-1:0] pwrgate_ack_ni,
    input  logic                 err_clear_i,
    output logic [N_DOMAINS-1:0] clk_en_o,
    output logic [N_DOMAINS-1:0] iso_o,
    output logic [N_DOMAINS-1:0] set_retentive_no,
    output logic [N_DOMAINS-1:0] pwrgate_no,
    output logic [N_DOMAINS-1:0] domain_on_o,
    output logic [N_DOMAINS-1:0] busy_o,
    output logic [N_DOMAINS-1:0] err_o,
    output logic                 irq_o
);

    // One counter serves both the clock-gate settle delay and the ack timeout,
    // so it is sized for the larger of the two and saturates instead of wrapping.
    localparam int CNT_MAX = (CG_DELAY > ACK_TIMEOUT) ? CG_DELAY : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CG_LAST  = CNT_W'(CG_DELAY - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(ACK_TIMEOUT);

    // Output bundle order: {clk_en, iso, set_retentive_n, pwrgate_n}
    localparam logic [3:0] OUT_RESET = 4'b1011;

    typedef enum logic [3:0] {
        ST_ON      = 4'd0,
        ST_CLK_OFF = 4'd1,
        ST_ISO     = 4'd2,
        ST_RET     = 4'd3,
        ST_PG      = 4'd4,
        ST_OFF     = 4'd5,
        ST_PU      = 4'd6,
        ST_UNRET   = 4'd7,
        ST_DEISO   = 4'd8,
        ST_CLK_ON  = 4'd9
    } state_t;

    // Macro-facing controls as a pure function of state. Registering this
    // value of the next state keeps every output aligned with its state.
    function automatic logic [3:0] seq_outputs(input state_t st, input logic retain);
        logic [3:0] o;
        case (st)
            ST_ON:      o = 4'b1011;
            ST_CLK_OFF: o = 4'b0011;
            ST_ISO:     o = 4'b0111;
            ST_RET:     o = {1'b0, 1'b1, ~retain, 1'b1};
            ST_PG:      o = {1'b0, 1'b1, ~retain, 1'b0};
            ST_OFF:     o = {1'b0, 1'b1, ~retain, 1'b0};
            ST_PU:      o = {1'b0, 1'b1, ~retain, 1'b1};
            ST_UNRET:   o = 4'b0111;
            ST_DEISO:   o = 4'b0011;
            ST_CLK_ON:  o = 4'b0011;
            default:    o = OUT_RESET;
        endcase
        return o;
    endfunction

    logic [N_DOMAINS-1:0] err_next_s;
    logic                 irq_r;

    for (genvar d = 0; d < N_DOMAINS; d++) begin : g_dom
        state_t           state_r, state_s;
        logic [CNT_W-1:0] cnt_r, cnt_s;
        logic             retain_r, retain_s;
        logic             err_r, err_s, err_set_s;
        logic [3:0]       out_r;
        logic             on_r, busy_r;

        // Next-state, counter and timeout detection for this domain.
        always_comb begin
            state_s   = state_r;
            cnt_s     = cnt_r;
            retain_s  = retain_r;
            err_set_s = 1'b0;
            case (state_r)
                ST_ON: begin
                    // Wake wins a tie, so a simultaneous pair keeps the domain up.
                    if (sleep_req_i[d] && !wake_req_i[d]) begin
                        state_s  = ST_CLK_OFF;
                        retain_s = retain_i[d];
                        cnt_s    = CNT_ZERO;
                    end else begin
                        state_s = ST_ON;
                    end
                end
                ST_CLK_OFF: begin
                    if (cnt_r == CG_LAST) begin
                        state_s = ST_ISO;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_ISO: begin
                    state_s = ST_RET;
                end
                ST_RET: begin
                    state_s = ST_PG;
                    cnt_s   = CNT_ZERO;
                end
                ST_PG: begin
                    if (!pwrgate_ack_ni[d]) begin
                        state_s = ST_OFF;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        if (cnt_r != TO_MAX) begin
                            cnt_s = cnt_r + CNT_ONE;
                        end else begin
                            cnt_s = cnt_r;
                        end
                        if (cnt_r == TO_LAST) begin
                            err_set_s = 1'b1;
                        end else begin
                            err_set_s = 1'b0;
                        end
                    end
                end
                ST_OFF: begin
                    if (wake_req_i[d]) begin
                        state_s = ST_PU;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_OFF;
                    end
                end
                ST_PU: begin
                    if (pwrgate_ack_ni[d]) begin
                        state_s = ST_UNRET;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        if (cnt_r != TO_MAX) begin
                            cnt_s = cnt_r + CNT_ONE;
                        end else begin
                            cnt_s = cnt_r;
                        end
                        if (cnt_r == TO_LAST) begin
                            err_set_s = 1'b1;
                        end else begin
                            err_set_s = 1'b0;
                        end
                    end
                end
                ST_UNRET: begin
                    state_s = ST_DEISO;
                end
                ST_DEISO: begin
                    state_s = ST_CLK_ON;
                    cnt_s   = CNT_ZERO;
                end
                ST_CLK_ON: begin
                    if (cnt_r == CG_LAST) begin
                        state_s = ST_ON;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_ON;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end

        // Sticky error: a new timeout beats a clear arriving in the same cycle.
        always_comb begin
            if (err_set_s) begin
                err_s = 1'b1;
            end else if (err_clear_i) begin
                err_s = 1'b0;
            end else begin
                err_s = err_r;
            end
        end

        assign err_next_s[d] = err_s;

        // Domain state, counter and registered outputs; reset lands in ON.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_r  <= ST_ON;
                cnt_r    <= CNT_ZERO;
                retain_r <= 1'b0;
                err_r    <= 1'b0;
                out_r    <= OUT_RESET;
                on_r     <= 1'b1;
                busy_r   <= 1'b0;
            end else begin
                state_r  <= state_s;
                cnt_r    <= cnt_s;
                retain_r <= retain_s;
                err_r    <= err_s;
                out_r    <= seq_outputs(state_s, retain_s);
                on_r     <= (state_s == ST_ON);
                busy_r   <= !((state_s == ST_ON) || (state_s == ST_OFF));
            end
        end

        assign clk_en_o[d]         = out_r[3];
        assign iso_o[d]            = out_r[2];
        assign set_retentive_no[d] = out_r[1];
        assign pwrgate_no[d]       = out_r[0];
        assign domain_on_o[d]      = on_r;
        assign busy_o[d]           = busy_r;
        assign err_o[d]            = err_r;
    end

    // Interrupt is registered from the same next-error vector as err_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |err_next_s;
        end
    end

    assign irq_o = irq_r;

endmodule

// File: tb/tb_eros_domain_pwr_seq.sv
// Bench for eros_domain_pwr_seq. A timeline model turns each accepted
// request into the list of expected output changes (with their cycle), a
// monitor pops and compares them as the DUT outputs move, and a macro
// responder returns the power-switch ack after a chosen delay.
module tb_eros_domain_pwr_seq;

    localparam int N     = 3;
    localparam int CG    = 2;
    localparam int TO    = 255;
    localparam int STUCK = TO + 45;

    // {clk_en, iso, set_retentive_n, pwrgate_n, domain_on, busy, err}
    typedef struct packed {
        logic clk_en;
        logic iso;
        logic ret_n;
        logic pg_n;
        logic on;
        logic busy;
        logic err;
    } snap_t;

    typedef struct packed {
        int unsigned t;
        snap_t       s;
    } ev_t;

    localparam snap_t RST_SNAP = 7'b1011100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sleep_req = '0;
    logic [N-1:0] wake_req  = '0;
    logic [N-1:0] retain    = '0;
    logic [N-1:0] ack_n     = '1;
    logic         err_clear = 1'b0;
    logic [N-1:0] clk_en, iso, ret_n, pg_n, dom_on, busy, err;
    logic         irq;

    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    // Reference timeline state
    snap_t       cur_m  [N];
    int unsigned ready  [N];
    bit          is_off [N];
    int unsigned adly   [N];
    int unsigned a_pick [N];
    ev_t         q      [N][$];

    // Responder state
    logic        last_pg [N];
    int unsigned chg     [N];

    // Monitor state
    snap_t mon_prev [N];
    snap_t mon_exp  [N];

    eros_domain_pwr_seq #(
        .N_DOMAINS  (N),
        .CG_DELAY   (CG),
        .ACK_TIMEOUT(TO)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .sleep_req_i     (sleep_req),
        .wake_req_i      (wake_req),
        .retain_i        (retain),
        .pwrgate_ack_ni  (ack_n),
        .err_clear_i     (err_clear),
        .clk_en_o        (clk_en),
        .iso_o           (iso),
        .set_retentive_no(ret_n),
        .pwrgate_no      (pg_n),
        .domain_on_o     (dom_on),
        .busy_o          (busy),
        .err_o           (err),
        .irq_o           (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected change list: merge entries sharing a cycle, drop no-op steps.
    task automatic push_ev(input int d, input int unsigned t, input snap_t s);
        ev_t ev;
        if (s !== cur_m[d]) begin
            if (q[d].size() > 0 && q[d][q[d].size()-1].t == t) begin
                ev = q[d].pop_back();
            end
            ev.t = t;
            ev.s = s;
            q[d].push_back(ev);
            cur_m[d] = s;
        end
    endtask

    task automatic sleep_start(input int d, input int unsigned t0, input logic r, input int unsigned a);
        snap_t       s;
        int unsigned te;
        s = cur_m[d];
        s.clk_en = 1'b0; s.on = 1'b0; s.busy = 1'b1; push_ev(d, t0, s);
        s.iso = 1'b1;                                 push_ev(d, t0 + CG, s);
        s.ret_n = ~r;                                 push_ev(d, t0 + CG + 1, s);
        te = t0 + CG + 2;
        s.pg_n = 1'b0;                                push_ev(d, te, s);
        if (a >= TO) begin s.err = 1'b1;              push_ev(d, te + TO, s); end
        s.busy = 1'b0;                                push_ev(d, te + 1 + a, s);
        ready[d]  = te + 2 + a;
        is_off[d] = 1'b1;
        adly[d]   = a;
    endtask

    task automatic wake_start(input int d, input int unsigned w0, input int unsigned a);
        snap_t       s;
        int unsigned tn;
        s = cur_m[d];
        s.pg_n = 1'b1; s.busy = 1'b1;                 push_ev(d, w0, s);
        if (a >= TO) begin s.err = 1'b1;              push_ev(d, w0 + TO, s); end
        s.ret_n = 1'b1;                               push_ev(d, w0 + 1 + a, s);
        s.iso = 1'b0;                                 push_ev(d, w0 + 2 + a, s);
        tn = w0 + 3 + a + CG;
        s.clk_en = 1'b1; s.on = 1'b1; s.busy = 1'b0;  push_ev(d, tn, s);
        ready[d]  = tn + 1;
        is_off[d] = 1'b0;
        adly[d]   = a;
    endtask

    // Apply the request rules to the inputs that the next clock edge samples.
    task automatic model_edge();
        int unsigned e;
        snap_t       s;
        e = cyc + 1;
        if (err_clear) begin
            for (int d = 0; d < N; d++) begin
                if (cur_m[d].err) begin
                    s = cur_m[d];
                    s.err = 1'b0;
                    push_ev(d, e, s);
                end
            end
        end
        for (int d = 0; d < N; d++) begin
            if (e >= ready[d]) begin
                if (!is_off[d] && sleep_req[d] && !wake_req[d]) begin
                    sleep_start(d, e, retain[d], a_pick[d]);
                end else if (is_off[d] && wake_req[d]) begin
                    wake_start(d, e, a_pick[d]);
                end
            end
        end
    endtask

    function automatic bit all_stable();
        bit ok;
        ok = 1'b1;
        for (int d = 0; d < N; d++) begin
            if (ready[d] > cyc + 1) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic step();
        model_edge();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Power-switch macro: ack follows pwrgate_no after adly cycles.
    always @(negedge clk) begin
        for (int d = 0; d < N; d++) begin
            if (pg_n[d] !== last_pg[d]) begin
                last_pg[d] = pg_n[d];
                chg[d]     = cyc;
            end
            if (cyc - chg[d] >= adly[d]) ack_n[d] = pg_n[d];
        end
    end

    // Monitor: every output change must match the next expected entry.
    always @(negedge clk) begin : monitor
        snap_t a;
        ev_t   ev;
        logic  any_err;
        if (mon_en) begin
            any_err = 1'b0;
            for (int d = 0; d < N; d++) begin
                a = {clk_en[d], iso[d], ret_n[d], pg_n[d], dom_on[d], busy[d], err[d]};
                if (a !== mon_prev[d]) begin
                    checks++;
                    if (q[d].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change dom%0d: got %b at cycle %0d, expected %b held",
                                 d, a, cyc, mon_prev[d]);
                    end else begin
                        ev = q[d].pop_front();
                        mon_exp[d] = ev.s;
                        if (ev.t != cyc || ev.s !== a) begin
                            errors++;
                            $display("FAIL output_event dom%0d: got %b at cycle %0d, expected %b at cycle %0d",
                                     d, a, cyc, ev.s, ev.t);
                        end
                    end
                    mon_prev[d] = a;
                end else if (q[d].size() > 0 && q[d][0].t <= cyc) begin
                    checks++;
                    errors++;
                    ev = q[d].pop_front();
                    mon_exp[d] = ev.s;
                    $display("FAIL missing_event dom%0d: got %b held at cycle %0d, expected %b at cycle %0d",
                             d, a, cyc, ev.s, ev.t);
                end
                any_err = any_err | mon_exp[d].err;
            end
            checks++;
            if (irq !== any_err) begin
                errors++;
                $display("FAIL irq: got %b, expected %b at cycle %0d", irq, any_err, cyc);
            end
        end
    end

    initial begin
        for (int d = 0; d < N; d++) begin
            cur_m[d]    = RST_SNAP;
            mon_prev[d] = RST_SNAP;
            mon_exp[d]  = RST_SNAP;
            ready[d]    = 0;
            is_off[d]   = 1'b0;
            adly[d]     = 0;
            a_pick[d]   = 0;
            last_pg[d]  = 1'b1;
            chg[d]      = 0;
        end
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (10) step();

        check("rst_clk_en", 32'(clk_en), 32'(3'b111));
        check("rst_iso",    32'(iso),    32'(3'b000));
        check("rst_ret_n",  32'(ret_n),  32'(3'b111));
        check("rst_pg_n",   32'(pg_n),   32'(3'b111));
        check("rst_on",     32'(dom_on), 32'(3'b111));
        check("rst_busy",   32'(busy),   32'(3'b000));
        check("rst_err",    32'(err),    32'(3'b000));
        check("rst_irq",    32'(irq),    32'(1'b0));

        // Domain 0 sleeps with retention, ack two cycles late
        retain[0] = 1'b1; a_pick[0] = 2; sleep_req[0] = 1'b1; step();
        sleep_req[0] = 1'b0; repeat (12) step();

        // Domain 1 sleeps without retention, then wakes
        retain[1] = 1'b0; a_pick[1] = 1; sleep_req[1] = 1'b1; step();
        sleep_req[1] = 1'b0; repeat (12) step();
        wake_req[1] = 1'b1; step();
        wake_req[1] = 1'b0; repeat (12) step();
        check("dom1_on_after_wake", 32'(dom_on[1]), 32'(1'b1));

        // Domain 2 sleeps with a stuck ack: timeout, late ack, then clear
        a_pick[2] = STUCK; retain[2] = 1'b1; sleep_req[2] = 1'b1; step();
        sleep_req[2] = 1'b0; repeat (STUCK + 10) step();
        check("err2_after_timeout", 32'(err[2]), 32'(1'b1));
        check("dom2_off_after_ack", 32'(busy[2]), 32'(1'b0));
        err_clear = 1'b1; step();
        err_clear = 1'b0; step();
        check("err_after_clear", 32'(err), 32'(3'b000));

        // Tie keeps domain 1 on; then wake raised during ISO is deferred
        sleep_req[1] = 1'b1; wake_req[1] = 1'b1; repeat (5) step();
        check("tie_stays_on", 32'(dom_on[1]), 32'(1'b1));
        wake_req[1] = 1'b0; a_pick[1] = 0; step();
        repeat (CG) step();
        check("dom1_in_iso", 32'(iso[1]), 32'(1'b1));
        sleep_req[1] = 1'b0; wake_req[1] = 1'b1; repeat (14) step();
        wake_req[1] = 1'b0;
        wake_req[0] = 1'b1; a_pick[0] = 1; step();
        wake_req[0] = 1'b0; repeat (10) step();

        // Randomized traffic on all domains
        for (int i = 0; i < 1500; i++) begin
            for (int d = 0; d < N; d++) begin
                if ($urandom_range(7, 0) == 0) sleep_req[d] = ($urandom_range(1, 0) == 1);
                if ($urandom_range(7, 0) == 0) wake_req[d]  = ($urandom_range(2, 0) == 0);
                retain[d] = ($urandom_range(1, 0) == 1);
                a_pick[d] = ($urandom_range(39, 0) == 0) ? STUCK : $urandom_range(4, 0);
            end
            err_clear = all_stable() && ($urandom_range(15, 0) == 0);
            step();
        end
        sleep_req = '0; wake_req = '0; err_clear = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (all_stable()) break;
            step();
        end
        check("drain_done", 32'(all_stable()), 32'(1'b1));
        repeat (2) step();
        for (int d = 0; d < N; d++) begin
            check("events_consumed", 32'(q[d].size()), 32'd0);
        end

        // Asynchronous reset while domain 0 waits in PG
        if (is_off[0]) begin
            wake_req[0] = 1'b1; a_pick[0] = 0; step();
            wake_req[0] = 1'b0; repeat (CG + 6) step();
        end
        a_pick[0] = STUCK; sleep_req[0] = 1'b1; step();
        sleep_req[0] = 1'b0; repeat (CG + 5) step();
        check("dom0_in_pg", 32'(pg_n[0]), 32'(1'b0));
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("arst_clk_en", 32'(clk_en), 32'(3'b111));
        check("arst_iso",    32'(iso),    32'(3'b000));
        check("arst_ret_n",  32'(ret_n),  32'(3'b111));
        check("arst_pg_n",   32'(pg_n),   32'(3'b111));
        check("arst_on",     32'(dom_on), 32'(3'b111));
        check("arst_busy",   32'(busy),   32'(3'b000));
        check("arst_err",    32'(err),    32'(3'b000));
        check("arst_irq",    32'(irq),    32'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
